// File: rtl/i2d_id_if.sv
// Fetch/execute handshake and decoded-slot bundle for the i2d decode stage.
// The stage uses the slave modport; the fetch/execute side uses master.
interface i2d_id_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALU_OP_W = 4
);
  logic                if_valid;
  logic [XLEN-1:0]     if_ins;
  logic [XLEN-1:0]     if_pc;
  logic                if_ready;
  logic                flush;
  logic                ex_ready;
  logic                id_valid;
  logic [XLEN-1:0]     id_ins;
  logic [XLEN-1:0]     id_pc;
  logic [XLEN-1:0]     imm;
  logic [REG_AW-1:0]   rf_rd;
  logic [REG_AW-1:0]   rf_ra;
  logic [REG_AW-1:0]   rf_rb;
  logic                rf_r;
  logic [ALU_OP_W-1:0] alu_op;
  logic                id_err;
  logic                swi;
  logic                branch;
  logic                call;

  modport master (
    output if_valid, if_ins, if_pc, flush, ex_ready,
    input  if_ready, id_valid, id_ins, id_pc, imm, rf_rd, rf_ra, rf_rb,
           rf_r, alu_op, id_err, swi, branch, call
  );

  modport slave (
    input  if_valid, if_ins, if_pc, flush, ex_ready,
    output if_ready, id_valid, id_ins, id_pc, imm, rf_rd, rf_ra, rf_rb,
           rf_r, alu_op, id_err, swi, branch, call
  );
endinterface

// File: rtl/i2d_id_stage.sv
// i2d decode stage: valid/ready slot between fetch and execute, blocks fetch after a trap.
// Define I2D_ID_PERF_EN to add the perf_dec / perf_stall counters.
module i2d_id_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned IMM_R_W  = 21,
  parameter int unsigned IMM_NR_W = 26,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic clk,
  input  logic rst,
  i2d_id_if.slave bus
`ifdef I2D_ID_PERF_EN
  ,
  output logic [31:0] perf_dec,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned OP_LSB = XLEN - OP_W;
  localparam int unsigned RD_MSB = OP_LSB - 1;
  localparam int unsigned RA_MSB = RD_MSB - REG_AW;
  localparam int unsigned RB_MSB = RA_MSB - REG_AW;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_TRAP_FULL = 2'd2,
    ST_TRAP_WAIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]     op;
  logic [XLEN-1:0]     imm_r_sext;
  logic [XLEN-1:0]     imm_nr_sext;
  logic [XLEN-1:0]     dec_imm;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_rf_r;
  logic                dec_err;
  logic                dec_swi;
  logic                dec_branch;
  logic                dec_call;
  logic                dec_trap;

  logic ready_c;
  logic accept_c;
  logic valid_d;

  logic                id_valid_q;
  logic [XLEN-1:0]     id_ins_q;
  logic [XLEN-1:0]     id_pc_q;
  logic [XLEN-1:0]     imm_q;
  logic [REG_AW-1:0]   rf_rd_q;
  logic [REG_AW-1:0]   rf_ra_q;
  logic [REG_AW-1:0]   rf_rb_q;
  logic                rf_r_q;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic                id_err_q;
  logic                swi_q;
  logic                branch_q;
  logic                call_q;

  assign op          = bus.if_ins[XLEN-1 -: OP_W];
  assign imm_r_sext  = {{(XLEN-IMM_R_W){bus.if_ins[IMM_R_W-1]}}, bus.if_ins[IMM_R_W-1:0]};
  assign imm_nr_sext = {{(XLEN-IMM_NR_W){bus.if_ins[IMM_NR_W-1]}}, bus.if_ins[IMM_NR_W-1:0]};

  // Opcode decode of the instruction presented by fetch
  always_comb begin
    dec_imm    = '0;
    dec_alu_op = '0;
    dec_rf_r   = 1'b0;
    dec_err    = 1'b0;
    dec_swi    = 1'b0;
    dec_branch = 1'b0;
    dec_call   = 1'b0;
    if (op[5:4] == 2'b00 && op[3:0] <= 4'hD) begin
      dec_alu_op = ALU_OP_W'(op[3:0]);
      dec_rf_r   = 1'b1;
    end else if (op[5:4] == 2'b01 && op[3:0] <= 4'hD) begin
      dec_alu_op = ALU_OP_W'(op[3:0]);
      dec_rf_r   = 1'b1;
      dec_imm    = imm_r_sext;
    end else begin
      case (op)
        6'h1E: begin
          dec_alu_op = ALU_OP_W'(4'hF);
          dec_imm    = imm_r_sext;
        end
        6'h20: begin
          dec_branch = 1'b1;
          dec_imm    = imm_nr_sext;
        end
        6'h21: begin
          dec_call = 1'b1;
          dec_imm  = imm_nr_sext;
        end
        6'h30:   dec_swi = 1'b1;
        6'h3F:   ;
        default: dec_err = 1'b1;
      endcase
    end
    dec_trap = dec_swi | dec_err;
  end

  // Slot control: flush overrides every transition
  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    accept_c = 1'b0;
    if (rst && !bus.flush) begin
      ready_c = (state_q == ST_EMPTY) || (state_q == ST_FULL && bus.ex_ready);
    end
    accept_c = bus.if_valid & ready_c;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) state_d = dec_trap ? ST_TRAP_FULL : ST_FULL;
      end
      ST_FULL: begin
        if (accept_c)         state_d = dec_trap ? ST_TRAP_FULL : ST_FULL;
        else if (bus.ex_ready) state_d = ST_EMPTY;
      end
      ST_TRAP_FULL: begin
        if (bus.ex_ready) state_d = ST_TRAP_WAIT;
      end
      ST_TRAP_WAIT: ;
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) state_d = ST_EMPTY;
    valid_d = (state_d == ST_FULL) || (state_d == ST_TRAP_FULL);
  end

  // Output slot; payload may go stale once the slot empties, flags do not
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      id_valid_q <= 1'b0;
      id_ins_q   <= '0;
      id_pc_q    <= '0;
      imm_q      <= '0;
      rf_rd_q    <= '0;
      rf_ra_q    <= '0;
      rf_rb_q    <= '0;
      rf_r_q     <= 1'b0;
      alu_op_q   <= '0;
      id_err_q   <= 1'b0;
      swi_q      <= 1'b0;
      branch_q   <= 1'b0;
      call_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= valid_d;
      if (accept_c) begin
        id_ins_q <= bus.if_ins;
        id_pc_q  <= bus.if_pc;
        imm_q    <= dec_imm;
        rf_rd_q  <= bus.if_ins[RD_MSB -: REG_AW];
        rf_ra_q  <= bus.if_ins[RA_MSB -: REG_AW];
        rf_rb_q  <= bus.if_ins[RB_MSB -: REG_AW];
        rf_r_q   <= dec_rf_r;
        alu_op_q <= dec_alu_op;
        id_err_q <= dec_err;
        swi_q    <= dec_swi;
        branch_q <= dec_branch;
        call_q   <= dec_call;
      end else if (!valid_d) begin
        rf_r_q   <= 1'b0;
        id_err_q <= 1'b0;
        swi_q    <= 1'b0;
        branch_q <= 1'b0;
        call_q   <= 1'b0;
      end
    end
  end

`ifdef I2D_ID_PERF_EN
  // Accept and stall counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_dec   <= '0;
      perf_stall <= '0;
    end else begin
      if (accept_c)                    perf_dec   <= perf_dec + 32'd1;
      if (id_valid_q && !bus.ex_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  assign bus.if_ready = ready_c;
  assign bus.id_valid = id_valid_q;
  assign bus.id_ins   = id_ins_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.imm      = imm_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_ra    = rf_ra_q;
  assign bus.rf_rb    = rf_rb_q;
  assign bus.rf_r     = rf_r_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.id_err   = id_err_q;
  assign bus.swi      = swi_q;
  assign bus.branch   = branch_q;
  assign bus.call     = call_q;

endmodule

// File: tb/tb_i2d_id_stage.sv
// Self-checking bench for i2d_id_stage: scenario tasks plus a scoreboard monitor.
// Perf counter checks are included when I2D_ID_PERF_EN is defined.
module tb_i2d_id_stage;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int ST_E  = 0;
  localparam int ST_F  = 1;
  localparam int ST_TF = 2;
  localparam int ST_TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  i2d_id_if #(.XLEN(XLEN), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)) bus ();

`ifdef I2D_ID_PERF_EN
  logic [31:0] perf_dec;
  logic [31:0] perf_stall;
`endif

  i2d_id_stage #(
    .XLEN(XLEN), .REG_AW(REG_AW), .IMM_R_W(21), .IMM_NR_W(26), .ALU_OP_W(ALU_OP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef I2D_ID_PERF_EN
    ,
    .perf_dec  (perf_dec),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        rf_r;
    logic        err;
    logic        swi;
    logic        br;
    logic        call;
    logic        trap;
  } exp_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  int   m_state = ST_E;
  logic s_rst = 1'b0, s_acc = 1'b0, s_ex = 1'b0, s_flush = 1'b0;
  logic [31:0] s_ins = '0, s_pc = '0;
  logic [31:0] m_dec = '0, m_stall = '0;

  // Reference decode written straight from the opcode table
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op;
    logic signed [31:0] t;
    e = '0;
    e.ins = ins; e.pc = pc;
    e.rd = ins[25:21]; e.ra = ins[20:16]; e.rb = ins[15:11];
    op = ins[31:26];
    if (op inside {[6'h00:6'h0D]}) begin
      e.alu = op[3:0]; e.rf_r = 1'b1;
    end else if (op inside {[6'h10:6'h1D]}) begin
      e.alu = op[3:0]; e.rf_r = 1'b1;
      t = {ins[20:0], 11'd0}; e.imm = 32'(t >>> 11);
    end else if (op == 6'h1E) begin
      e.alu = 4'hF;
      t = {ins[20:0], 11'd0}; e.imm = 32'(t >>> 11);
    end else if (op == 6'h20 || op == 6'h21) begin
      e.br = (op == 6'h20); e.call = (op == 6'h21);
      t = {ins[25:0], 6'd0}; e.imm = 32'(t >>> 6);
    end else if (op == 6'h30) begin
      e.swi = 1'b1;
    end else if (op != 6'h3F) begin
      e.err = 1'b1;
    end
    e.trap = e.swi | e.err;
    return e;
  endfunction

  // Pre-edge sampling and if_ready check against the model state
  always @(negedge clk) begin : mon_ready
    logic exp_ready;
    exp_ready = rst && !bus.flush && (m_state == ST_E || (m_state == ST_F && bus.ex_ready));
    n_chk++;
    if (bus.if_ready !== exp_ready)
      $display("FAIL if_ready: got %b want %b at %0t", bus.if_ready, exp_ready, $time);
    else n_pass++;
    s_rst = rst; s_flush = bus.flush; s_ex = bus.ex_ready;
    s_acc = bus.if_valid && exp_ready;
    s_ins = bus.if_ins; s_pc = bus.if_pc;
  end

  // Scoreboard: model state advance, then compare the registered slot
  always @(posedge clk) begin : mon_slot
    exp_t e;
    logic pre_valid, exp_valid;
    pre_valid = (m_state == ST_F || m_state == ST_TF);
    e = model(s_ins, s_pc);
    if (!s_rst) begin
      m_state = ST_E; sbq.delete(); m_dec = '0; m_stall = '0;
    end else begin
      if (s_acc) m_dec = m_dec + 32'd1;
      if (pre_valid && !s_ex) m_stall = m_stall + 32'd1;
      if (s_flush) begin
        m_state = ST_E; sbq.delete();
      end else begin
        case (m_state)
          ST_E: if (s_acc) begin sbq.push_back(e); m_state = e.trap ? ST_TF : ST_F; end
          ST_F: if (s_ex) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            if (s_acc) begin sbq.push_back(e); m_state = e.trap ? ST_TF : ST_F; end
            else m_state = ST_E;
          end
          ST_TF: if (s_ex) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            m_state = ST_TW;
          end
          default: ;
        endcase
      end
    end
    #1;
    exp_valid = (m_state == ST_F || m_state == ST_TF);
    n_chk++;
    if (bus.id_valid !== exp_valid)
      $display("FAIL id_valid: got %b want %b at %0t", bus.id_valid, exp_valid, $time);
    else n_pass++;
    if (!s_rst) begin
      n_chk++;
      if ({bus.id_ins, bus.id_pc, bus.imm, bus.alu_op, bus.rf_rd, bus.rf_ra, bus.rf_rb,
           bus.rf_r, bus.id_err, bus.swi, bus.branch, bus.call} !== '0)
        $display("FAIL reset_clear: id_ins %h imm %h flags %b%b%b%b%b want all 0 at %0t",
                 bus.id_ins, bus.imm, bus.rf_r, bus.id_err, bus.swi, bus.branch, bus.call, $time);
      else n_pass++;
    end else if (s_flush) begin
      n_chk++;
      if ({bus.id_err, bus.swi, bus.branch, bus.call} !== 4'b0)
        $display("FAIL flush_flags: got %b%b%b%b want 0000 at %0t",
                 bus.id_err, bus.swi, bus.branch, bus.call, $time);
      else n_pass++;
    end else if (exp_valid && sbq.size() > 0) begin
      e = sbq[0];
      n_chk++;
      if ({bus.id_ins, bus.id_pc} !== {e.ins, e.pc})
        $display("FAIL slot_payload: got %h/%h want %h/%h at %0t", bus.id_ins, bus.id_pc, e.ins, e.pc, $time);
      else n_pass++;
      n_chk++;
      if (bus.imm !== e.imm)
        $display("FAIL slot_imm: got %h want %h ins %h at %0t", bus.imm, e.imm, e.ins, $time);
      else n_pass++;
      n_chk++;
      if (bus.alu_op !== e.alu)
        $display("FAIL slot_alu_op: got %h want %h ins %h at %0t", bus.alu_op, e.alu, e.ins, $time);
      else n_pass++;
      n_chk++;
      if ({bus.rf_rd, bus.rf_ra, bus.rf_rb} !== {e.rd, e.ra, e.rb})
        $display("FAIL slot_regs: got %0d %0d %0d want %0d %0d %0d at %0t",
                 bus.rf_rd, bus.rf_ra, bus.rf_rb, e.rd, e.ra, e.rb, $time);
      else n_pass++;
      n_chk++;
      if ({bus.rf_r, bus.id_err, bus.swi, bus.branch, bus.call} !== {e.rf_r, e.err, e.swi, e.br, e.call})
        $display("FAIL slot_flags: got %b%b%b%b%b want %b%b%b%b%b ins %h at %0t",
                 bus.rf_r, bus.id_err, bus.swi, bus.branch, bus.call,
                 e.rf_r, e.err, e.swi, e.br, e.call, e.ins, $time);
      else n_pass++;
    end
`ifdef I2D_ID_PERF_EN
    n_chk++;
    if ({perf_dec, perf_stall} !== {m_dec, m_stall})
      $display("FAIL perf: got dec %0d stall %0d want %0d %0d at %0t", perf_dec, perf_stall, m_dec, m_stall, $time);
    else n_pass++;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_chk++;
    if (bus.id_valid !== 1'b0 || bus.id_ins !== 32'h0)
      $display("FAIL reset_state: id_valid %b id_ins %h want 0", bus.id_valid, bus.id_ins);
    else n_pass++;
    n_chk++;
    if (bus.if_ready !== 1'b0) $display("FAIL reset_if_ready: got %b want 0", bus.if_ready);
    else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    bus.if_ins = 32'h4000_0005; bus.if_pc = 32'h0000_0100;
    bus.if_valid = 1'b1; bus.ex_ready = 1'b1;
    tick();
    bus.if_valid = 1'b0;
    n_chk++;
    if (bus.id_valid !== 1'b1 || bus.alu_op !== 4'h0 || bus.imm !== 32'h5 || bus.rf_r !== 1'b1)
      $display("FAIL addi: valid %b alu %h imm %h rf_r %b want 1 0 00000005 1",
               bus.id_valid, bus.alu_op, bus.imm, bus.rf_r);
    else n_pass++;
    #1;
    n_chk++;
    if (bus.if_ready !== 1'b1) $display("FAIL addi_if_ready: got %b want 1", bus.if_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_branch();
    bus.if_ins = {6'h20, 26'h3FF_FFFC}; bus.if_pc = 32'h0000_0200; bus.if_valid = 1'b1;
    tick();
    bus.if_valid = 1'b0;
    n_chk++;
    if (bus.imm !== 32'hFFFF_FFFC || bus.branch !== 1'b1 || bus.rf_r !== 1'b0)
      $display("FAIL branch: imm %h br %b rf_r %b want fffffffc 1 0", bus.imm, bus.branch, bus.rf_r);
    else n_pass++;
    tick();
  endtask

  task automatic test_movi();
    bus.if_ins = {6'h1E, 5'd3, 21'h10_0000}; bus.if_pc = 32'h0000_0204; bus.if_valid = 1'b1;
    tick();
    bus.if_valid = 1'b0;
    n_chk++;
    if (bus.imm !== 32'hFFF0_0000 || bus.alu_op !== 4'hF || bus.rf_rd !== 5'd3)
      $display("FAIL movi: imm %h alu %h rd %0d want fff00000 f 3", bus.imm, bus.alu_op, bus.rf_rd);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ins_a, ins_b;
`ifdef I2D_ID_PERF_EN
    logic [31:0] base;
`endif
    ins_a = {6'h02, 5'd1, 5'd2, 5'd3, 11'd0};
    ins_b = {6'h13, 5'd4, 5'd5, 16'hFFFF};
    bus.if_ins = ins_a; bus.if_pc = 32'h0000_0300; bus.if_valid = 1'b1; bus.ex_ready = 1'b0;
    tick();
`ifdef I2D_ID_PERF_EN
    base = perf_stall;
`endif
    bus.if_ins = ins_b; bus.if_pc = 32'h0000_0304;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (bus.if_ready !== 1'b0 || bus.id_ins !== ins_a || bus.id_pc !== 32'h0000_0300 || bus.id_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: ready %b ins %h pc %h valid %b want 0 %h 00000300 1",
                 i, bus.if_ready, bus.id_ins, bus.id_pc, bus.id_valid, ins_a);
      else n_pass++;
      tick();
    end
    bus.ex_ready = 1'b1;
    #1;
    n_chk++;
    if (bus.if_ready !== 1'b1) $display("FAIL stall_release: if_ready %b want 1", bus.if_ready);
    else n_pass++;
`ifdef I2D_ID_PERF_EN
    n_chk++;
    if (perf_stall - base !== 32'd3) $display("FAIL perf_stall_delta: got %0d want 3", perf_stall - base);
    else n_pass++;
`endif
    tick();
    bus.if_valid = 1'b0;
    n_chk++;
    if (bus.id_valid !== 1'b1 || bus.id_ins !== ins_b || bus.imm !== 32'h0005_FFFF)
      $display("FAIL no_bubble: valid %b ins %h imm %h want 1 %h 0005ffff", bus.id_valid, bus.id_ins, bus.imm, ins_b);
    else n_pass++;
    tick();
  endtask

  task automatic test_trap();
    bus.if_ins = {6'h3A, 26'h0}; bus.if_pc = 32'h0000_0400; bus.if_valid = 1'b1; bus.ex_ready = 1'b0;
    tick();
    n_chk++;
    if (bus.id_err !== 1'b1 || bus.id_valid !== 1'b1)
      $display("FAIL trap_err: id_err %b id_valid %b want 1 1", bus.id_err, bus.id_valid);
    else n_pass++;
    bus.ex_ready = 1'b1; bus.if_ins = {6'h01, 26'h0};
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      n_chk++;
      if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b0)
        $display("FAIL trap_wait[%0d]: id_valid %b if_ready %b want 0 0", i, bus.id_valid, bus.if_ready);
      else n_pass++;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.if_valid = 1'b0;
    #1;
    n_chk++;
    if (bus.if_ready !== 1'b1 || bus.id_err !== 1'b0)
      $display("FAIL trap_flush: if_ready %b id_err %b want 1 0", bus.if_ready, bus.id_err);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush_accept();
    bus.if_ins = {6'h21, 26'h000_0010}; bus.if_pc = 32'h0000_0500;
    bus.if_valid = 1'b1; bus.flush = 1'b1;
    #1;
    n_chk++;
    if (bus.if_ready !== 1'b0) $display("FAIL flush_gate: if_ready %b want 0", bus.if_ready);
    else n_pass++;
    tick();
    bus.if_valid = 1'b0; bus.flush = 1'b0;
    n_chk++;
    if (bus.id_valid !== 1'b0 || bus.call !== 1'b0)
      $display("FAIL flush_drop: id_valid %b call %b want 0 0", bus.id_valid, bus.call);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [6];
    logic [31:0] ins;
    ops = '{6'h01, 6'h11, 6'h1E, 6'h20, 6'h21, 6'h3F};
    bus.ex_ready = 1'b1; bus.if_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ins = {ops[i], 26'($urandom)};
      bus.if_ins = ins; bus.if_pc = 32'h0000_0600 + 32'(i * 4);
      tick();
      n_chk++;
      if (bus.id_valid !== 1'b1 || bus.id_ins !== ins)
        $display("FAIL b2b[%0d]: valid %b ins %h want 1 %h", i, bus.id_valid, bus.id_ins, ins);
      else n_pass++;
    end
    bus.if_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int i = 0; i < 300; i++) begin
      op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) op = 6'($urandom_range(0, 33));
      bus.if_ins   = {op, 26'($urandom)};
      bus.if_pc    = 32'($urandom);
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.if_valid = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.if_ins = {6'h12, 5'd7, 5'd8, 16'h8000}; bus.if_pc = 32'h0000_0700;
    bus.if_valid = 1'b1; bus.ex_ready = 1'b0;
    tick();
    bus.if_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_chk++;
    if ({bus.id_valid, bus.id_ins, bus.id_pc, bus.imm, bus.alu_op, bus.rf_rd, bus.rf_r} !== '0)
      $display("FAIL reset_mid: valid %b ins %h pc %h imm %h alu %h rd %0d rf_r %b want all 0",
               bus.id_valid, bus.id_ins, bus.id_pc, bus.imm, bus.alu_op, bus.rf_rd, bus.rf_r);
    else n_pass++;
    n_chk++;
    if (bus.if_ready !== 1'b0) $display("FAIL reset_mid_ready: got %b want 0", bus.if_ready);
    else n_pass++;
`ifdef I2D_ID_PERF_EN
    n_chk++;
    if (perf_dec !== 32'd0 || perf_stall !== 32'd0)
      $display("FAIL reset_mid_perf: dec %0d stall %0d want 0 0", perf_dec, perf_stall);
    else n_pass++;
`endif
    rst = 1'b1;
    bus.ex_ready = 1'b1;
    tick();
  endtask

  initial begin
    bus.if_valid = 1'b0; bus.if_ins = '0; bus.if_pc = '0;
    bus.flush = 1'b0; bus.ex_ready = 1'b0;
    test_reset();
    test_addi();
    test_branch();
    test_movi();
    test_backpressure();
    test_trap();
    test_flush_accept();
    test_back_to_back();
    test_random();
    test_reset_mid();
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
